// File: rtl/rtype_encoder.sv
// RV32I R-type encoder with DEPTH-entry output FIFO; optional err_cnt via RTYPE_ENC_ERR_CNT_EN.
// Latency: one cycle from accepted request to out_valid; sustains one push and one pop per cycle.
// Backpressure: in_ready drops only when the FIFO is full and never depends on out_ready.
module rtype_encoder #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_alu_ctrl,
   input  logic [4:0]               in_rd,
   input  logic [4:0]               in_rs1,
   input  logic [4:0]               in_rs2,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [$clog2(DEPTH):0]   count,
`ifdef RTYPE_ENC_ERR_CNT_EN
   output logic [15:0]              err_cnt,
`endif
   output logic                     err_illegal
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [6:0]    OPCODE_OP = 7'b0110011;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          legal;
   logic [2:0]    funct3;
   logic [6:0]    funct7;
   logic [31:0]   word;
   logic          take;
   logic          push;
   logic          pop;

   always_comb begin
      legal  = 1'b1;
      funct3 = 3'b000;
      funct7 = 7'b0000000;
      case (in_alu_ctrl)
         4'b0000: funct3 = 3'b111;
         4'b0001: funct3 = 3'b110;
         4'b0010: funct3 = 3'b000;
         4'b0011: funct3 = 3'b001;
         4'b0100: begin
            funct3 = 3'b000;
            funct7 = 7'b0100000;
         end
         4'b0101: funct3 = 3'b101;
         4'b0111: funct3 = 3'b100;
         4'b1000: funct3 = 3'b010;
         default: legal = 1'b0;
      endcase
   end

   assign word = {funct7, in_rs2, in_rs1, funct3, in_rd, OPCODE_OP};

   assign in_ready  = (count != CNT_FULL);
   assign out_valid = (count != '0);
   assign take      = in_valid & in_ready;
   assign push      = take & legal;
   assign pop       = out_valid & out_ready;
   assign out_instr = out_valid ? mem[rd_ptr] : 32'h0;

   // Storage is not reset: out_instr is masked by out_valid instead.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem[wr_ptr] <= word;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         err_illegal <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push && !pop) begin
            count <= count + CNT_ONE;
         end else if (pop && !push) begin
            count <= count - CNT_ONE;
         end
         err_illegal <= take & ~legal;
      end
   end

`ifdef RTYPE_ENC_ERR_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_cnt <= 16'h0;
      end else if (take && !legal && err_cnt != 16'hFFFF) begin
         err_cnt <= err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rtype_encoder.sv
// Randomized bench for rtype_encoder against a queue-based reference model.
module tb_rtype_encoder;
   localparam int DEPTH = 4;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   in_valid = 1'b0;
   logic                   in_ready;
   logic [3:0]             in_alu_ctrl = 4'h0;
   logic [4:0]             in_rd = 5'h0;
   logic [4:0]             in_rs1 = 5'h0;
   logic [4:0]             in_rs2 = 5'h0;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [31:0]            out_instr;
   logic [$clog2(DEPTH):0] count;
   logic                   err_illegal;
`ifdef RTYPE_ENC_ERR_CNT_EN
   logic [15:0]            err_cnt;
`endif

   rtype_encoder #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_alu_ctrl (in_alu_ctrl),
      .in_rd       (in_rd),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .count       (count),
`ifdef RTYPE_ENC_ERR_CNT_EN
      .err_cnt     (err_cnt),
`endif
      .err_illegal (err_illegal)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [31:0] model_q[$];
   bit          m_err = 1'b0;
   int          m_errcnt = 0;
   logic [3:0]  legal_ops[8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference encoding straight from the operation table.
   function automatic void ref_enc(input logic [3:0] a, input int rd, input int rs1, input int rs2,
                                   output logic [31:0] w, output bit leg);
      int f3, f7;
      leg = 1'b1;
      f7  = 0;
      f3  = 0;
      case (a)
         4'h2: f3 = 0;
         4'h4: begin f3 = 0; f7 = 32; end
         4'h3: f3 = 1;
         4'h8: f3 = 2;
         4'h7: f3 = 4;
         4'h5: f3 = 5;
         4'h1: f3 = 6;
         4'h0: f3 = 7;
         default: leg = 1'b0;
      endcase
      w = f7 * (2**25) + rs2 * (2**20) + rs1 * (2**15) + f3 * (2**12) + rd * (2**7) + 51;
   endfunction

   task automatic cyc(input bit v, input logic [3:0] a, input int d, input int s1, input int s2,
                      input bit ordy, input bit rs);
      bit          rdy_m, vld_m, take, leg;
      logic [31:0] w;
      in_valid    = v;
      in_alu_ctrl = a;
      in_rd       = d[4:0];
      in_rs1      = s1[4:0];
      in_rs2      = s2[4:0];
      out_ready   = ordy;
      rst_n       = rs;
      rdy_m = (model_q.size() != DEPTH);
      vld_m = (model_q.size() != 0);
      ref_enc(a, d, s1, s2, w, leg);
      @(posedge clk);
      if (!rs) begin
         model_q.delete();
         m_err    = 1'b0;
         m_errcnt = 0;
      end else begin
         if (vld_m && ordy) void'(model_q.pop_front());
         take = v && rdy_m;
         if (take && leg) model_q.push_back(w);
         m_err = take && !leg;
         if (take && !leg && m_errcnt != 65535) m_errcnt++;
      end
      #1;
      chk("count", 32'(count), model_q.size());
      chk("in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
      chk("out_instr", out_instr, (model_q.size() != 0) ? model_q[0] : 32'h0);
      chk("err_illegal", 32'(err_illegal), 32'(m_err));
`ifdef RTYPE_ENC_ERR_CNT_EN
      chk("err_cnt", 32'(err_cnt), m_errcnt);
`endif
   endtask

   task automatic rand_push(input bit ordy);
      cyc(1'b1, legal_ops[$urandom_range(0, 7)], $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 31), ordy, 1'b1);
   endtask

   task automatic idle(input bit ordy);
      cyc(1'b0, 4'h0, 0, 0, 0, ordy, 1'b1);
   endtask

   initial begin
      cyc(1'b0, 4'h0, 0, 0, 0, 1'b0, 1'b0);
      cyc(1'b0, 4'h0, 0, 0, 0, 1'b0, 1'b0);
      chk("reset_count", 32'(count), 0);
      chk("reset_in_ready", 32'(in_ready), 1);

      // ADD x1,x2,x3
      cyc(1'b1, 4'h2, 1, 2, 3, 1'b0, 1'b1);
      chk("add_word", out_instr, 32'h003100B3);
      chk("add_count", 32'(count), 1);
      idle(1'b1);

      // SUB then SLT, popped in order
      cyc(1'b1, 4'h4, 5, 6, 7, 1'b0, 1'b1);
      cyc(1'b1, 4'h8, 1, 1, 1, 1'b0, 1'b1);
      chk("sub_word", out_instr, 32'h407302B3);
      idle(1'b1);
      chk("slt_word", out_instr, 32'h0010A0B3);
      idle(1'b1);

      // Fill to full, single pop, refill, repeated across pointer wrap
      for (int r = 0; r < 5; r++) begin
         while (model_q.size() < DEPTH) rand_push(1'b0);
         chk("full_in_ready", 32'(in_ready), 0);
         rand_push(1'b0);
         cyc(1'b0, 4'h0, 0, 0, 0, 1'b1, 1'b1);
         chk("pop_in_ready", 32'(in_ready), 1);
         chk("pop_count", 32'(count), DEPTH - 1);
      end
      while (model_q.size() != 0) idle(1'b1);

      // Streaming: one in, one out per cycle
      rand_push(1'b0);
      for (int i = 0; i < 20; i++) begin
         rand_push(1'b1);
         chk("stream_count", 32'(count), 1);
      end
      idle(1'b1);

      // Illegal code consumed, nothing queued
      cyc(1'b1, 4'hF, 3, 4, 5, 1'b0, 1'b1);
      chk("illegal_pulse", 32'(err_illegal), 1);
      chk("illegal_count", 32'(count), 0);
      idle(1'b0);
      chk("illegal_pulse_end", 32'(err_illegal), 0);
      cyc(1'b1, 4'h6, 1, 1, 1, 1'b0, 1'b1);
      cyc(1'b1, 4'h9, 1, 1, 1, 1'b0, 1'b1);
      chk("illegal_b2b", 32'(err_illegal), 1);

      // Reset mid-stream with a request present
      for (int i = 0; i < 3; i++) rand_push(1'b0);
      cyc(1'b1, 4'h2, 1, 2, 3, 1'b1, 1'b0);
      chk("midrst_count", 32'(count), 0);
      chk("midrst_out_instr", out_instr, 32'h0);

      // Random traffic including illegal codes
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'b1);
      end
      while (model_q.size() != 0) idle(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rtype_encoder.md
# rtype_encoder

Buffered RV32I R-type instruction encoder: the inverse of the core's ALU control decoder. Accepts an ALU operation code plus register indices on a valid/ready input, packs them into a 32-bit R-type instruction word, and queues the word in a DEPTH-entry FIFO. The FIFO drains on a valid/ready output. The block sits between the self-test/boot sequencer and instruction memory or the fetch path, so the team can generate instruction streams that round-trip through the decoder.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_alu_ctrl  input  4  ALU operation, decoder encoding: AND=0000, OR=0001, ADD=0010, SLL=0011, SUB=0100, SRL=0101, XOR=0111, SLT=1000.
- in_rd, in_rs1, in_rs2  input  5 each  register indices.
- out_valid  output  1  out_instr holds a queued word.
- out_ready  input  1  consumer takes the word.
- out_instr  output  32  encoded instruction at FIFO head.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- err_illegal  output  1  one-cycle pulse: an illegal alu_ctrl was consumed.
- err_cnt  output  16  illegal-request counter; present only with RTYPE_ENC_ERR_CNT_EN.

## Operation
- Word format: {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
- funct3 per operation: ADD/SUB=000, SLL=001, SLT=010, XOR=100, SRL=101, OR=110, AND=111.
- funct7 is 0100000 for SUB and 0000000 for every other operation.
- in_ready = (count != DEPTH). It is registered-state only, with no combinational dependence on out_ready.
- Input handshake: in_valid & in_ready at a rising edge.
  - Legal code: the word is written at the tail and the write pointer advances.
  - Illegal code (0110, 1001–1111): the request is consumed and nothing is enqueued. err_illegal is 1 in the following cycle.
- Output handshake: out_valid & out_ready at a rising edge pops the head.
- out_valid = (count != 0). out_instr is 32'h0 whenever out_valid=0.
- Simultaneous legal push and pop: count unchanged, both pointers advance. A push while full is impossible because in_ready=0.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- rd/rs1/rs2 = 0 are encoded verbatim; there is no special handling of x0.

## Timing
- Reset (rst_n=0 at an edge) sets:
  - count=0, read/write pointers=0, out_valid=0, out_instr=0, in_ready=1, err_illegal=0, err_cnt=0.
  - FIFO storage need not be cleared.
- A reset asserted mid-stream discards all queued words. Handshakes in that cycle are ignored.
- Latency: a legal request accepted at edge N into an empty FIFO gives out_valid=1 with the word on out_instr in the cycle after edge N.
- Throughput: one push and one pop per cycle sustained. A full FIFO with out_ready=1 reasserts in_ready in the cycle after the pop.
- err_illegal is a registered pulse, high for exactly one cycle per illegal request. Back-to-back illegal requests hold it high continuously.

## Configuration
- RTYPE_ENC_ERR_CNT_EN defined:
  - err_cnt increments on each consumed illegal request and saturates at 16'hFFFF.
  - err_cnt clears only on reset.
- RTYPE_ENC_ERR_CNT_EN undefined:
  - The err_cnt port and its register are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then in {alu=0010, rd=1, rs1=2, rs2=3} with out_ready=0 → next cycle out_valid=1, out_instr=32'h003100B3, count=1.
- Push SUB {rd=5, rs1=6, rs2=7} then SLT {rd=1, rs1=1, rs2=1} → pops yield 32'h407302B3, then 32'h0010A0B3, in order.
- Push DEPTH legal words with out_ready=0 → in_ready=0 at count=DEPTH. Set out_ready=1 for one cycle → count=DEPTH-1 and in_ready=1 the next cycle. Repeat across pointer wrap; no word is lost or duplicated.
- Continuous push and pop with in_valid=out_ready=1 for 20 cycles → count stays at 1 and every word emerges one cycle after acceptance.
- Illegal in_alu_ctrl=4'b1111 → accepted, count unchanged, err_illegal=1 for one cycle. With RTYPE_ENC_ERR_CNT_EN, err_cnt=1.
- Fill 3 entries, assert rst_n=0 for one edge together with in_valid=1 → count=0, out_valid=0, out_instr=0, and the request is not enqueued.
